// File: rtl/btb_ftq_pkg.sv
// Shared definitions for the fetch target queue: address width, branch types
// and the 75-bit queue entry layout.
package btb_ftq_pkg;

   localparam int INST_ADDR_W = 32;
   typedef logic [INST_ADDR_W-1:0] inst_addr_t;

   typedef enum logic [2:0] {
      TYPE_NONE     = 3'd0,
      TYPE_BRANCH   = 3'd1,
      TYPE_JUMP     = 3'd2,
      TYPE_CALL     = 3'd3,
      TYPE_RET      = 3'd4,
      TYPE_INDIRECT = 3'd5
   } br_type_e;

   // Entry layout, MSB to LSB: {FetchPc, NextPc, Offset, Mode, Type, HitBanN}
   localparam int ENT_W     = 75;
   localparam int HIT_LSB   = 0;
   localparam int TYPE_LSB  = 2;
   localparam int MODE_LSB  = 5;
   localparam int OFF_LSB   = 6;
   localparam int NPC_LSB   = 11;
   localparam int PC_LSB    = 43;

   typedef struct packed {
      inst_addr_t  pc;
      inst_addr_t  npc;
      logic [4:0]  off;
      logic        mode;
      logic [2:0]  typ;
      logic [1:0]  hit;
   } ftq_entry_t;

   function automatic inst_addr_t block_align(input inst_addr_t pc);
      return {pc[INST_ADDR_W-1:5], 5'd0};
   endfunction

endpackage

// File: rtl/btb_ftq_ram.sv
// Entry storage for the fetch target queue: synchronous write, asynchronous read.
module btb_ftq_ram
   import btb_ftq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [ENT_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [ENT_W-1:0] rdata
);

   logic [ENT_W-1:0] mem_q [DEPTH];

   // Contents are deliberately left unreset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/btb_ftq.sv
// Fetch target queue behind the BTB: buffers prediction packets with their
// fetch-block PC and hands them to instruction fetch in order.
module btb_ftq
   import btb_ftq_pkg::*;
#(
   parameter int FTQ_DEPTH = 8,
   parameter int IDX_W     = $clog2(FTQ_DEPTH)
) (
   input  logic             Clk,
   input  logic             Rest,
   input  logic             InstPcAble,
   input  logic [31:0]      InstPc,
   input  logic             FtqFlash,
   input  logic             InstNextAble,
   input  logic [1:0]       InstHitBanN,
   input  logic [31:0]      InstNextPc,
   input  logic [4:0]       InstNextOffset,
   input  logic             InstNextMode,
   input  logic [2:0]       InstNextType,
   output logic             BtbStop,
   output logic             FetchValid,
   input  logic             FetchReady,
   output logic [31:0]      FetchPc,
   output logic [31:0]      FetchNextPc,
   output logic [4:0]       FetchOffset,
   output logic             FetchMode,
   output logic [2:0]       FetchType,
   output logic [1:0]       FetchHitBanN,
   output logic [IDX_W-1:0] FetchIdx
);

   localparam logic [IDX_W:0] DEPTH_C  = (IDX_W+1)'(FTQ_DEPTH);
   localparam logic [IDX_W:0] STOP_LVL = (IDX_W+1)'(FTQ_DEPTH - 1);

   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             stop_q, stop_d;
   inst_addr_t       pc_q, pc_d;
   logic             pc_able_q, pc_able_d;
   logic             enq, deq;
   ftq_entry_t       wr_ent, rd_ent;
   logic [ENT_W-1:0] rd_raw;

   // Stall one slot early so the packet already inside the BTB always fits.
   assign BtbStop    = (count_q >= STOP_LVL);
   assign FetchValid = (count_q != '0);

   always_comb begin
      pc_d      = pc_q;
      pc_able_d = pc_able_q;
      stop_d    = BtbStop;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      enq       = InstNextAble & ~stop_q & ~FtqFlash;
      deq       = FetchValid & FetchReady & ~FtqFlash;

      if (!BtbStop) begin
         pc_d      = InstPc;
         pc_able_d = InstPcAble;
      end

      if (enq) begin
         tail_d = tail_q + 1'b1;
      end
      if (deq) begin
         head_d = head_q + 1'b1;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (FtqFlash) begin
         pc_able_d = 1'b0;
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
      end
   end

   always_comb begin
      wr_ent      = '0;
      wr_ent.pc   = block_align(pc_q);
      wr_ent.npc  = InstNextPc;
      wr_ent.off  = InstNextOffset;
      wr_ent.mode = InstNextMode;
      wr_ent.typ  = InstNextType;
      wr_ent.hit  = InstHitBanN;
   end

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         stop_q    <= 1'b0;
         pc_q      <= '0;
         pc_able_q <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         stop_q    <= stop_d;
         pc_q      <= pc_d;
         pc_able_q <= pc_able_d;
      end
   end

   btb_ftq_ram #(
      .DEPTH (FTQ_DEPTH),
      .AW    (IDX_W)
   ) u_ftq_ram (
      .clk   (Clk),
      .we    (enq),
      .waddr (tail_q),
      .wdata (wr_ent),
      .raddr (head_q),
      .rdata (rd_raw)
   );

   assign rd_ent       = rd_raw;
   assign FetchPc      = rd_ent.pc;
   assign FetchNextPc  = rd_ent.npc;
   assign FetchOffset  = rd_ent.off;
   assign FetchMode    = rd_ent.mode;
   assign FetchType    = rd_ent.typ;
   assign FetchHitBanN = rd_ent.hit;
   assign FetchIdx     = head_q;

   // The aligned request-valid is kept for the BTB update path, not consumed here.
   logic unused_pc_able;
   assign unused_pc_able = pc_able_q;

   a_count_bound: assert property (@(posedge Clk) disable iff (!Rest) count_q <= DEPTH_C);

endmodule

// File: tb/tb_btb_ftq.sv
// Scoreboard bench for btb_ftq: a small BTB model feeds packets, expected
// entries are queued on enqueue and compared when fetch dequeues them.
module tb_btb_ftq;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [4:0]  off;
      logic        mode;
      logic [2:0]  typ;
      logic [1:0]  hit;
   } pkt_t;

   typedef struct packed {
      pkt_t       p;
      logic [2:0] idx;
   } exp_t;

   logic        Clk;
   logic        Rest;
   logic        InstPcAble;
   logic [31:0] InstPc;
   logic        FtqFlash;
   logic        InstNextAble;
   logic [1:0]  InstHitBanN;
   logic [31:0] InstNextPc;
   logic [4:0]  InstNextOffset;
   logic        InstNextMode;
   logic [2:0]  InstNextType;
   logic        BtbStop;
   logic        FetchValid;
   logic        FetchReady;
   logic [31:0] FetchPc;
   logic [31:0] FetchNextPc;
   logic [4:0]  FetchOffset;
   logic        FetchMode;
   logic [2:0]  FetchType;
   logic [1:0]  FetchHitBanN;
   logic [2:0]  FetchIdx;

   btb_ftq #(.FTQ_DEPTH(8)) dut (
      .Clk            (Clk),
      .Rest           (Rest),
      .InstPcAble     (InstPcAble),
      .InstPc         (InstPc),
      .FtqFlash       (FtqFlash),
      .InstNextAble   (InstNextAble),
      .InstHitBanN    (InstHitBanN),
      .InstNextPc     (InstNextPc),
      .InstNextOffset (InstNextOffset),
      .InstNextMode   (InstNextMode),
      .InstNextType   (InstNextType),
      .BtbStop        (BtbStop),
      .FetchValid     (FetchValid),
      .FetchReady     (FetchReady),
      .FetchPc        (FetchPc),
      .FetchNextPc    (FetchNextPc),
      .FetchOffset    (FetchOffset),
      .FetchMode      (FetchMode),
      .FetchType      (FetchType),
      .FetchHitBanN   (FetchHitBanN),
      .FetchIdx       (FetchIdx)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int         n_checks = 0;
   int         n_pass   = 0;
   int         seq      = 0;
   exp_t       sb[$];
   logic [2:0] enq_idx  = '0;
   logic       req_on   = 1'b0;
   logic       req_able = 1'b0;
   pkt_t       req_pkt  = '0;
   logic       btb_valid = 1'b0;
   logic       btb_fresh = 1'b1;
   pkt_t       btb_pkt  = '0;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
   endtask

   function automatic pkt_t make_pkt(input int s);
      pkt_t p;
      p.pc   = 32'h0000_0800 + 32'(s << 5) + 32'((s * 7) % 32);
      p.npc  = 32'h0000_1000 + 32'((s - 1) << 5);
      p.off  = 5'((s * 3) % 32);
      p.mode = 1'(s % 2);
      p.typ  = 3'(s % 8);
      case (s % 3)
         0:       p.hit = 2'b00;
         1:       p.hit = 2'b01;
         default: p.hit = 2'b10;
      endcase
      return p;
   endfunction

   task automatic driveInputs();
      InstPcAble     = req_able;
      InstPc         = req_pkt.pc;
      InstNextAble   = btb_valid;
      InstNextPc     = btb_pkt.npc;
      InstNextOffset = btb_pkt.off;
      InstNextMode   = btb_pkt.mode;
      InstNextType   = btb_pkt.typ;
      InstHitBanN    = btb_pkt.hit;
   endtask

   // One clock: check this cycle, update the scoreboard, advance the BTB model.
   task automatic applyStimulus();
      exp_t e;
      logic stop_prev;
      logic flush_now;
      #1;
      checkOutput("fetch_valid", 64'(FetchValid), 64'(sb.size() != 0));
      checkOutput("btb_stop", 64'(BtbStop), 64'(sb.size() >= 7));
      stop_prev = BtbStop;
      flush_now = FtqFlash;
      if (flush_now) begin
         sb.delete();
         enq_idx = '0;
      end else begin
         if (FetchValid && FetchReady && sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("idx", 64'(FetchIdx), 64'(e.idx));
            checkOutput("pc", 64'(FetchPc), 64'(e.p.pc));
            checkOutput("npc", 64'(FetchNextPc), 64'(e.p.npc));
            checkOutput("off", 64'(FetchOffset), 64'(e.p.off));
            checkOutput("mode", 64'(FetchMode), 64'(e.p.mode));
            checkOutput("type", 64'(FetchType), 64'(e.p.typ));
            checkOutput("hit", 64'(FetchHitBanN), 64'(e.p.hit));
         end
         if (btb_valid && btb_fresh) begin
            e.p     = btb_pkt;
            e.p.pc  = {btb_pkt.pc[31:5], 5'd0};
            e.idx   = enq_idx;
            enq_idx = enq_idx + 3'd1;
            sb.push_back(e);
         end
      end
      @(posedge Clk);
      #1;
      if (flush_now) begin
         btb_valid = 1'b0;
         btb_fresh = 1'b1;
         req_able  = 1'b0;
      end else if (!stop_prev) begin
         btb_valid = req_able;
         btb_pkt   = req_pkt;
         btb_fresh = 1'b1;
      end else begin
         btb_fresh = 1'b0;
      end
      if (!stop_prev && !flush_now) begin
         if (req_on) begin
            seq++;
            req_pkt  = make_pkt(seq);
            req_able = 1'b1;
         end else begin
            req_able = 1'b0;
         end
      end
      driveInputs();
   endtask

   task automatic drainAll(input string tag);
      req_on     = 1'b0;
      FetchReady = 1'b1;
      for (int i = 0; i < 60 && (sb.size() != 0 || btb_valid || req_able); i++) applyStimulus();
      applyStimulus();
      checkOutput(tag, 64'(FetchValid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Rest       = 1'b0;
      FtqFlash   = 1'b0;
      FetchReady = 1'b0;
      driveInputs();
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("rst_valid", 64'(FetchValid), 64'd0);
      checkOutput("rst_stop", 64'(BtbStop), 64'd0);
      checkOutput("rst_idx", 64'(FetchIdx), 64'd0);
      Rest = 1'b1;

      // Three packets with fetch ready: idx 0,1,2 and next PCs 0x1000..0x1040
      FetchReady = 1'b1;
      req_on     = 1'b1;
      repeat (3) applyStimulus();
      req_on = 1'b0;
      drainAll("burst_drained");

      // Fill with fetch stalled, hold through the stall window, then drain in order
      FetchReady = 1'b0;
      req_on     = 1'b1;
      repeat (16) applyStimulus();
      #1;
      checkOutput("full_stop", 64'(BtbStop), 64'd1);
      checkOutput("full_valid", 64'(FetchValid), 64'd1);
      drainAll("full_drained");

      // Reach four entries, then enqueue and dequeue together across the wrap
      FetchReady = 1'b0;
      req_on     = 1'b1;
      for (int i = 0; i < 20 && sb.size() < 4; i++) applyStimulus();
      FetchReady = 1'b1;
      repeat (12) applyStimulus();
      #1;
      checkOutput("steady_stop", 64'(BtbStop), 64'd0);
      checkOutput("steady_valid", 64'(FetchValid), 64'd1);
      drainAll("steady_drained");

      // Flush at five entries with a packet in flight
      FetchReady = 1'b0;
      req_on     = 1'b1;
      for (int i = 0; i < 20 && sb.size() < 5; i++) applyStimulus();
      FtqFlash = 1'b1;
      req_on   = 1'b0;
      applyStimulus();
      FtqFlash = 1'b0;
      checkOutput("flush_valid", 64'(FetchValid), 64'd0);
      checkOutput("flush_stop", 64'(BtbStop), 64'd0);
      repeat (4) applyStimulus();

      // Flush while the BTB is stalled
      req_on = 1'b1;
      for (int i = 0; i < 20 && !BtbStop; i++) applyStimulus();
      repeat (3) applyStimulus();
      FtqFlash = 1'b1;
      req_on   = 1'b0;
      applyStimulus();
      FtqFlash = 1'b0;
      checkOutput("stall_flush_stop", 64'(BtbStop), 64'd0);
      drainAll("post_flush_drained");

      // Asynchronous reset in the middle of a stream
      FetchReady = 1'b0;
      req_on     = 1'b1;
      repeat (5) applyStimulus();
      #2;
      Rest = 1'b0;
      #1;
      checkOutput("arst_valid", 64'(FetchValid), 64'd0);
      checkOutput("arst_stop", 64'(BtbStop), 64'd0);
      checkOutput("arst_idx", 64'(FetchIdx), 64'd0);
      sb.delete();
      enq_idx   = '0;
      btb_valid = 1'b0;
      btb_fresh = 1'b1;
      req_able  = 1'b0;
      driveInputs();
      @(posedge Clk);
      #1;
      Rest       = 1'b1;
      FetchReady = 1'b1;
      repeat (6) applyStimulus();
      drainAll("after_reset_drained");

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
